// File: rtl/md_ctrl_pkg.sv
// Shared types and constants for the multiply/divide stall controller.
package md_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    localparam int MD_CNT_W        = 4;
    localparam int STALL_CNT_W     = 16;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; reusable for performance counters.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/md_stall_ctrl.sv
// MD unit busy sequencer plus combined fetch stall / E bubble and MD stall counter.
module md_stall_ctrl
    import md_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   E_md_start,
    input  logic                   E_md_is_div,
    input  logic                   D_md_use,
    input  logic                   other_stall,
    output logic                   IFU_STALL,
    output logic                   E_flush,
    output logic                   md_busy,
    output logic                   md_done,
    output logic                   md_is_div,
    output logic [MD_CNT_W-1:0]    md_cycles_left,
    output logic                   md_overlap,
    output logic [STALL_CNT_W-1:0] md_stall_cnt
);

    localparam int CNT_MAX = (1 << MD_CNT_W) - 1;

    if (MULT_CYCLES < 1 || MULT_CYCLES > CNT_MAX) begin : g_bad_mult
        $fatal(1, "md_stall_ctrl: MULT_CYCLES out of range 1..15");
    end
    if (DIV_CYCLES < 1 || DIV_CYCLES > CNT_MAX) begin : g_bad_div
        $fatal(1, "md_stall_ctrl: DIV_CYCLES out of range 1..15");
    end

    localparam logic [MD_CNT_W-1:0] MULT_LD = MD_CNT_W'(MULT_CYCLES);
    localparam logic [MD_CNT_W-1:0] DIV_LD  = MD_CNT_W'(DIV_CYCLES);
    localparam logic [MD_CNT_W-1:0] CNT_ONE = MD_CNT_W'(1);

    md_state_e             state_q, state_d;
    logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
    logic                  is_div_q, is_div_d;
    logic                  overlap_q;
    logic                  md_stall_src;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            overlap_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            overlap_q <= overlap_q | ((state_q == BUSY) & E_md_start);
        end
    end

    // Starts arriving while BUSY are dropped here; only the sticky overlap flag records them.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        md_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (E_md_start) begin
                    state_d  = BUSY;
                    cnt_d    = E_md_is_div ? DIV_LD : MULT_LD;
                    is_div_d = E_md_is_div;
                end
            end
            BUSY: begin
                if (cnt_q == CNT_ONE) begin
                    md_done = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Gated by reset so a start presented during reset cannot freeze fetch.
    assign md_busy        = (state_q == BUSY);
    assign md_stall_src   = reset & D_md_use & (md_busy | E_md_start);
    assign IFU_STALL      = other_stall | md_stall_src;
    assign E_flush        = IFU_STALL;
    assign md_is_div      = is_div_q;
    assign md_cycles_left = cnt_q;
    assign md_overlap     = overlap_q;

    sat_counter #(
        .WIDTH (STALL_CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (md_stall_src),
        .clear (1'b0),
        .count (md_stall_cnt)
    );

endmodule

// File: tb/tb_md_stall_ctrl.sv
// Directed vector bench for md_stall_ctrl (default latencies 5 / 10).
module tb_md_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        E_md_start, E_md_is_div, D_md_use, other_stall;
    logic        IFU_STALL, E_flush, md_busy, md_done, md_is_div, md_overlap;
    logic [3:0]  md_cycles_left;
    logic [15:0] md_stall_cnt;

    int errors = 0;
    int checks = 0;

    md_stall_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .E_md_start     (E_md_start),
        .E_md_is_div    (E_md_is_div),
        .D_md_use       (D_md_use),
        .other_stall    (other_stall),
        .IFU_STALL      (IFU_STALL),
        .E_flush        (E_flush),
        .md_busy        (md_busy),
        .md_done        (md_done),
        .md_is_div      (md_is_div),
        .md_cycles_left (md_cycles_left),
        .md_overlap     (md_overlap),
        .md_stall_cnt   (md_stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start, is_div, d_use, other;
        logic        stall, busy, done;
        logic [3:0]  left;
        logic        is_div_o, overlap;
        logic [15:0] cnt;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic s, input logic dv, input logic du, input logic o,
                       input logic st, input logic b, input logic dn, input logic [3:0] l,
                       input logic idv, input logic ov, input logic [15:0] c);
        vec_t v;
        v.start = s; v.is_div = dv; v.d_use = du; v.other = o;
        v.stall = st; v.busy = b; v.done = dn; v.left = l;
        v.is_div_o = idv; v.overlap = ov; v.cnt = c;
        vq.push_back(v);
    endtask

    // Drive one cycle's inputs at the falling edge, then settle combinational outputs.
    task automatic cyc(input logic s, input logic dv, input logic du, input logic o);
        @(negedge clk);
        E_md_start = s; E_md_is_div = dv; D_md_use = du; other_stall = o;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        E_md_start = 0; E_md_is_div = 0; D_md_use = 0; other_stall = 0;

        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_busy", md_busy, 0);
        chk("rst_left", md_cycles_left, 0);
        chk("rst_stall", IFU_STALL, 0);
        chk("rst_cnt", md_stall_cnt, 0);
        reset = 1'b1;
        #1;
        chk("post_rst_done", md_done, 0);
        chk("post_rst_isdiv", md_is_div, 0);
        chk("post_rst_overlap", md_overlap, 0);
        chk("post_rst_flush", E_flush, 0);

        // mult, no MD user in D; other_stall pulses while busy and while idle
        add(1, 0, 0, 0,  0, 0, 0, 4'd0, 0, 0, 16'd0);
        for (int k = 1; k <= 5; k++)
            add(0, 0, 0, (k == 3), (k == 3), 1, (k == 5), 4'(6 - k), 0, 0, 16'd0);
        add(0, 0, 0, 0,  0, 0, 0, 4'd0, 0, 0, 16'd0);
        add(0, 0, 0, 1,  1, 0, 0, 4'd0, 0, 0, 16'd0);
        // div with mflo held in D: stalled for t..t+10, 11 counted cycles
        add(1, 1, 1, 0,  1, 0, 0, 4'd0, 0, 0, 16'd0);
        for (int k = 1; k <= 10; k++)
            add(0, 0, 1, (k == 5), 1, 1, (k == 10), 4'(11 - k), 1, 0, 16'(k));
        add(0, 0, 1, 0,  0, 0, 0, 4'd0, 1, 0, 16'd11);
        add(0, 0, 1, 1,  1, 0, 0, 4'd0, 1, 0, 16'd11);
        add(0, 0, 0, 0,  0, 0, 0, 4'd0, 1, 0, 16'd11);

        foreach (vq[i]) begin
            cyc(vq[i].start, vq[i].is_div, vq[i].d_use, vq[i].other);
            chk($sformatf("v%0d_stall", i), IFU_STALL, vq[i].stall);
            chk($sformatf("v%0d_flush", i), E_flush, vq[i].stall);
            chk($sformatf("v%0d_busy", i), md_busy, vq[i].busy);
            chk($sformatf("v%0d_done", i), md_done, vq[i].done);
            chk($sformatf("v%0d_left", i), md_cycles_left, vq[i].left);
            chk($sformatf("v%0d_isdiv", i), md_is_div, vq[i].is_div_o);
            chk($sformatf("v%0d_overlap", i), md_overlap, vq[i].overlap);
            chk($sformatf("v%0d_cnt", i), md_stall_cnt, vq[i].cnt);
        end

        // overlap: div at t, illegal mult start at t+4 must not reload
        cyc(1, 1, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            cyc((k == 4), 0, 0, 0);
            if (k <= 10) chk($sformatf("ov_left_%0d", k), md_cycles_left, 11 - k);
            chk($sformatf("ov_done_%0d", k), md_done, (k == 10));
            chk($sformatf("ov_busy_%0d", k), md_busy, (k <= 10));
            chk($sformatf("ov_flag_%0d", k), md_overlap, (k >= 5));
        end
        chk("ov_isdiv", md_is_div, 1);
        chk("ov_cnt", md_stall_cnt, 16'd11);

        // reset during a div at t+3 aborts immediately
        cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0; E_md_start = 1; E_md_is_div = 1; D_md_use = 1; other_stall = 0;
        #1;
        chk("ar_busy", md_busy, 0);
        chk("ar_left", md_cycles_left, 0);
        chk("ar_done", md_done, 0);
        chk("ar_overlap", md_overlap, 0);
        chk("ar_isdiv", md_is_div, 0);
        chk("ar_cnt", md_stall_cnt, 0);
        chk("ar_stall_gated", IFU_STALL, 0);
        other_stall = 1;
        #1;
        chk("ar_stall_other", IFU_STALL, 1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            chk($sformatf("ar_hold_done_%0d", k), md_done, 0);
            chk($sformatf("ar_hold_busy_%0d", k), md_busy, 0);
        end

        // saturation: every cycle is an MD stall (start or busy with D user)
        @(negedge clk);
        reset = 1'b1; E_md_start = 1; E_md_is_div = 0; D_md_use = 1; other_stall = 0;
        repeat (65534) @(posedge clk);
        @(negedge clk); #1;
        chk("sat_fffe", md_stall_cnt, 16'hFFFE);
        @(negedge clk); #1;
        chk("sat_ffff", md_stall_cnt, 16'hFFFF);
        @(negedge clk); #1;
        chk("sat_hold", md_stall_cnt, 16'hFFFF);
        chk("sat_overlap", md_overlap, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
